// File: rtl/traffic_cmd_sequencer.sv
// Expands operator requests into the one-cycle command pulses the light controller expects.
// Build macro TRAFFIC_SEQ_CHECK_EN rejects RECONFIG requests that carry a zero time field.
module traffic_cmd_sequencer #(
  parameter int GAP_CYCLES = 2,
  parameter int DATA_W     = 16
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [DATA_W-1:0] req_green_ms_i,
  input  logic [DATA_W-1:0] req_red_ms_i,
  input  logic [DATA_W-1:0] req_yellow_ms_i,
  output logic [2:0]        cmd_type_o,
  output logic              cmd_valid_o,
  output logic [DATA_W-1:0] cmd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  localparam logic [1:0] OP_ON       = 2'b00;
  localparam logic [1:0] OP_OFF      = 2'b01;
  localparam logic [1:0] OP_SERVICE  = 2'b10;
  localparam logic [1:0] OP_RECONFIG = 2'b11;
  localparam logic [7:0] GAP_LAST    = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  state_t            state, next_state;
  logic [2:0]        step, next_step;
  logic [7:0]        gap_cnt, next_cnt;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] green_q, red_q, yellow_q;
  logic              load, reject, issue_next, done_next, err_next, last_step;
  logic [1:0]        cmd_op;
  logic [2:0]        cmd_type_next;
  logic [DATA_W-1:0] cmd_data_next;

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

`ifdef TRAFFIC_SEQ_CHECK_EN
  assign reject = (req_op_i == OP_RECONFIG) &&
                  ((req_green_ms_i == '0) || (req_red_ms_i == '0) || (req_yellow_ms_i == '0));
`else
  assign reject = 1'b0;
`endif

  assign last_step = (op_q == OP_RECONFIG) ? (step == 3'd4) : 1'b1;

  // Step 0 is issued on the accept edge, before the op is latched, so use the live op then.
  always_comb begin
    cmd_type_next = 3'b000;
    cmd_data_next = '0;
    cmd_op        = load ? req_op_i : op_q;
    case (cmd_op)
      OP_ON:      cmd_type_next = 3'b000;
      OP_OFF:     cmd_type_next = 3'b001;
      OP_SERVICE: cmd_type_next = 3'b010;
      default: begin
        case (next_step)
          3'd0: cmd_type_next = 3'b010;
          3'd1: begin cmd_type_next = 3'b011; cmd_data_next = green_q;  end
          3'd2: begin cmd_type_next = 3'b100; cmd_data_next = red_q;    end
          3'd3: begin cmd_type_next = 3'b101; cmd_data_next = yellow_q; end
          default: cmd_type_next = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    next_state = state;
    next_step  = step;
    next_cnt   = gap_cnt;
    load       = 1'b0;
    issue_next = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          load = 1'b1;
          if (reject) begin
            err_next = 1'b1;
          end else begin
            next_state = ISSUE;
            next_step  = 3'd0;
            issue_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        next_cnt = '0;
        if (GAP_CYCLES != 0) begin
          next_state = GAP;
        end else if (last_step) begin
          next_state = IDLE;
          done_next  = 1'b1;
        end else begin
          next_step  = step + 3'd1;
          issue_next = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (last_step) begin
            next_state = IDLE;
            done_next  = 1'b1;
          end else begin
            next_state = ISSUE;
            next_step  = step + 3'd1;
            issue_next = 1'b1;
          end
        end else begin
          next_cnt = gap_cnt + 8'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state       <= IDLE;
      step        <= '0;
      gap_cnt     <= '0;
      op_q        <= '0;
      green_q     <= '0;
      red_q       <= '0;
      yellow_q    <= '0;
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= '0;
      cmd_data_o  <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= next_state;
      step        <= next_step;
      gap_cnt     <= next_cnt;
      if (load) begin
        op_q     <= req_op_i;
        green_q  <= req_green_ms_i;
        red_q    <= req_red_ms_i;
        yellow_q <= req_yellow_ms_i;
      end
      cmd_valid_o <= issue_next;
      cmd_type_o  <= issue_next ? cmd_type_next : 3'b000;
      cmd_data_o  <= issue_next ? cmd_data_next : '0;
      done_o      <= done_next;
      err_o       <= err_next;
    end
  end

endmodule

// File: tb/tb_traffic_cmd_sequencer.sv
// Bench for traffic_cmd_sequencer: two instances (gap 2 and gap 0) share stimulus and are
// compared each cycle against a cycle-indexed timeline of expected outputs.
module tb_traffic_cmd_sequencer;

  localparam int DW   = 16;
  localparam int NCYC = 4096;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic          req_valid_i;
  logic [1:0]    req_op_i;
  logic [DW-1:0] req_green_ms_i, req_red_ms_i, req_yellow_ms_i;

  logic [1:0]    ready, busy, vld, done, err;
  logic [2:0]    typ [2];
  logic [DW-1:0] dat [2];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  bit          exp_valid [2][NCYC];
  bit          exp_busy  [2][NCYC];
  bit          exp_done  [2][NCYC];
  bit          exp_err   [2][NCYC];
  bit [2:0]    exp_type  [2][NCYC];
  bit [DW-1:0] exp_data  [2][NCYC];
  int          free_at   [2];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  traffic_cmd_sequencer #(.GAP_CYCLES(2), .DATA_W(DW)) u_gap2 (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(ready[0]), .req_op_i(req_op_i),
    .req_green_ms_i(req_green_ms_i), .req_red_ms_i(req_red_ms_i), .req_yellow_ms_i(req_yellow_ms_i),
    .cmd_type_o(typ[0]), .cmd_valid_o(vld[0]), .cmd_data_o(dat[0]),
    .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0])
  );

  traffic_cmd_sequencer #(.GAP_CYCLES(0), .DATA_W(DW)) u_gap0 (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(ready[1]), .req_op_i(req_op_i),
    .req_green_ms_i(req_green_ms_i), .req_red_ms_i(req_red_ms_i), .req_yellow_ms_i(req_yellow_ms_i),
    .cmd_type_o(typ[1]), .cmd_valid_o(vld[1]), .cmd_data_o(dat[1]),
    .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1])
  );

  function automatic int gapOf(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic checkCycle();
    for (int i = 0; i < 2; i++) begin
      string p;
      p = (i == 0) ? "g2" : "g0";
      checkOutput({p, ".ready"}, 32'(ready[i]), 32'(!exp_busy[i][cyc]));
      checkOutput({p, ".busy"},  32'(busy[i]),  32'(exp_busy[i][cyc]));
      checkOutput({p, ".valid"}, 32'(vld[i]),   32'(exp_valid[i][cyc]));
      checkOutput({p, ".type"},  32'(typ[i]),   32'(exp_type[i][cyc]));
      checkOutput({p, ".data"},  32'(dat[i]),   32'(exp_data[i][cyc]));
      checkOutput({p, ".done"},  32'(done[i]),  32'(exp_done[i][cyc]));
      checkOutput({p, ".err"},   32'(err[i]),   32'(exp_err[i][cyc]));
    end
  endtask

  // Reference: an accepted request becomes a list of (code, data) pulses placed on the timeline.
  task automatic modelAccept(int i);
    int       g, n_cmds, t, fin;
    bit       rej;
    bit [2:0] seq_t [5];
    bit [DW-1:0] seq_d [5];
    if (!req_valid_i || cyc < free_at[i]) return;
    g   = gapOf(i);
    rej = 1'b0;
`ifdef TRAFFIC_SEQ_CHECK_EN
    rej = (req_op_i == 2'b11) &&
          (req_green_ms_i == 0 || req_red_ms_i == 0 || req_yellow_ms_i == 0);
`endif
    if (rej) begin
      exp_err[i][cyc + 1] = 1'b1;
      return;
    end
    for (int n = 0; n < 5; n++) begin
      seq_t[n] = 3'd0;
      seq_d[n] = '0;
    end
    case (req_op_i)
      2'b00: begin n_cmds = 1; seq_t[0] = 3'd0; end
      2'b01: begin n_cmds = 1; seq_t[0] = 3'd1; end
      2'b10: begin n_cmds = 1; seq_t[0] = 3'd2; end
      default: begin
        n_cmds   = 5;
        seq_t[0] = 3'd2;
        seq_t[1] = 3'd3; seq_d[1] = req_green_ms_i;
        seq_t[2] = 3'd4; seq_d[2] = req_red_ms_i;
        seq_t[3] = 3'd5; seq_d[3] = req_yellow_ms_i;
        seq_t[4] = 3'd0;
      end
    endcase
    for (int n = 0; n < n_cmds; n++) begin
      t = cyc + 1 + n * (g + 1);
      exp_valid[i][t] = 1'b1;
      exp_type[i][t]  = seq_t[n];
      exp_data[i][t]  = seq_d[n];
    end
    fin = cyc + 1 + n_cmds * (g + 1);
    for (int c = cyc + 1; c < fin; c++) exp_busy[i][c] = 1'b1;
    exp_done[i][fin] = 1'b1;
    free_at[i]       = fin;
  endtask

  task automatic applyStimulus(bit v, logic [1:0] op, logic [DW-1:0] g, logic [DW-1:0] r,
                               logic [DW-1:0] y);
    req_valid_i     = v;
    req_op_i        = op;
    req_green_ms_i  = g;
    req_red_ms_i    = r;
    req_yellow_ms_i = y;
    modelAccept(0);
    modelAccept(1);
    @(negedge clk_i);
    checkCycle();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'b00, '0, '0, '0);
  endtask

  // Asynchronous reset in mid-cycle; everything pending on the timeline is abandoned.
  task automatic doReset();
    req_valid_i = 1'b0;
    #2 arstn_i = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst.valid", 32'(vld[i]),  32'd0);
      checkOutput("rst.busy",  32'(busy[i]), 32'd0);
      checkOutput("rst.done",  32'(done[i]), 32'd0);
      checkOutput("rst.type",  32'(typ[i]),  32'd0);
      checkOutput("rst.ready", 32'(ready[i]), 32'd1);
      for (int t = cyc + 1; t < NCYC; t++) begin
        exp_valid[i][t] = 1'b0;
        exp_busy[i][t]  = 1'b0;
        exp_done[i][t]  = 1'b0;
        exp_err[i][t]   = 1'b0;
        exp_type[i][t]  = '0;
        exp_data[i][t]  = '0;
      end
      free_at[i] = 0;
    end
    @(negedge clk_i);
    checkCycle();
    arstn_i = 1'b1;
  endtask

  function automatic logic [DW-1:0] rndField();
    return ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
  endfunction

  initial begin
    arstn_i         = 1'b0;
    req_valid_i     = 1'b0;
    req_op_i        = '0;
    req_green_ms_i  = '0;
    req_red_ms_i    = '0;
    req_yellow_ms_i = '0;
    free_at[0]      = 0;
    free_at[1]      = 0;
    repeat (2) begin
      @(negedge clk_i);
      checkCycle();
    end
    arstn_i = 1'b1;

    applyStimulus(1'b1, 2'b00, '0, '0, '0);
    idle(6);

    applyStimulus(1'b1, 2'b11, 16'd50, 16'd100, 16'd30);
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 2'b01, '0, '0, '0);
    idle(6);

    applyStimulus(1'b1, 2'b11, 16'd50, 16'd100, 16'd30);
    idle(4);
    doReset();
    applyStimulus(1'b1, 2'b10, '0, '0, '0);
    idle(6);

    applyStimulus(1'b1, 2'b11, 16'd7, 16'd9, 16'd0);
    idle(17);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                      rndField(), rndField(), rndField());
      end
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_cmd_sequencer.md
# traffic_cmd_sequencer

Command-side master for the traffic-light controller's command port (cmd_type/cmd_valid/cmd_data). It accepts high-level operator requests over a valid/ready handshake and expands each one into the exact one-cycle command pulses the controller expects. A timing reconfiguration always goes through yellow-blink service mode, since the controller only accepts time updates in that mode. It sits between the host/register block and the light controller, on the same clock.

## Interface
- GAP_CYCLES, 2: idle cycles inserted after every issued command pulse; range 0..255.
- DATA_W, 16: width of time fields and cmd_data_o.
- clk_i  in  1  clock.
- arstn_i  in  1  asynchronous reset, active low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i on a rising edge.
- req_op_i  in  2  00 ON, 01 OFF, 10 SERVICE, 11 RECONFIG.
- req_green_ms_i  in  DATA_W  green time in ms, used by RECONFIG only.
- req_red_ms_i  in  DATA_W  red time in ms, used by RECONFIG only.
- req_yellow_ms_i  in  DATA_W  yellow time in ms, used by RECONFIG only.
- cmd_type_o  out  3  command code to the controller.
- cmd_valid_o  out  1  one-cycle command strobe.
- cmd_data_o  out  DATA_W  command payload.
- busy_o  out  1  high while a sequence is in progress.
- done_o  out  1  one-cycle pulse when a sequence completes.
- err_o  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, ISSUE, GAP. A step index (0..4) selects the current command from the latched sequence.
- Sequences (command code, data):
  - ON: 000.
  - OFF: 001.
  - SERVICE: 010.
  - RECONFIG: 010, then 011/green, then 100/red, then 101/yellow, then 000. The final 000 returns the controller to RED.
- Data is 0 for every command that carries no time value.
- req_ready_o = (state == IDLE); it is combinational from state.
- On accept, op and all three time fields are latched. Inputs are don't-care after accept.
- IDLE -> ISSUE on accept.
- ISSUE lasts exactly one cycle with cmd_valid_o = 1. It then goes to GAP, or directly to the next ISSUE when GAP_CYCLES = 0.
- GAP counts GAP_CYCLES cycles, then moves to the next step's ISSUE.
- After the last command's gap, the block returns to IDLE. done_o is high in the first IDLE cycle.
- cmd_type_o and cmd_data_o are 0 whenever cmd_valid_o = 0.
- busy_o = (state != IDLE).
- Requests presented while busy are not accepted: req_valid_i is held off by ready. There is no queueing.
- Reset (arstn_i low, any time, including mid-sequence):
  - state IDLE, step 0, latched fields 0.
  - cmd_valid_o, cmd_type_o, cmd_data_o, done_o, err_o, busy_o all 0 immediately.
  - A partially issued sequence is abandoned; no done_o pulse.
- Reset release: req_ready_o = 1 from the first cycle.

## Timing
- Accept on edge k → first command visible in cycle k+1 (latency 1).
- Command n of a sequence (n = 0..) appears in cycle k+1+n·(GAP_CYCLES+1).
- Sequence of N commands: done_o and req_ready_o are high in cycle k+1+N·(GAP_CYCLES+1). A new request can be accepted on that edge.
- RECONFIG, GAP_CYCLES = 2: commands at k+1, k+4, k+7, k+10, k+13; done at k+16.
- GAP_CYCLES = 0: RECONFIG emits 5 consecutive cmd_valid_o cycles; done at k+6.
- All outputs are registered, except req_ready_o and busy_o, which are decoded from the state register.

## Configuration
- TRAFFIC_SEQ_CHECK_EN defined:
  - A RECONFIG with any time field equal to 0 is rejected.
  - The request is still accepted on edge k.
  - err_o pulses in cycle k+1, with no command issued; state is IDLE in k+1, so ready is high.
  - Other ops are never rejected.
- Undefined: no checking. Zero values are forwarded unchanged and err_o is tied to 0.

## Test plan
- ON request after reset, GAP_CYCLES = 2: accept at k → single pulse type 000, data 0 at k+1; done_o at k+4; busy_o high k+1..k+3.
- RECONFIG green=50, red=100, yellow=30: pulses 010/0, 011/50, 100/100, 101/30, 000/0 at k+1, k+4, k+7, k+10, k+13; done_o at k+16; exactly 5 cmd_valid_o cycles.
- req_valid_i held high with a second OFF request during a RECONFIG: ready stays low until k+16; OFF is accepted on the k+16 edge; pulse 001 at k+17.
- Reset asserted asynchronously between the 011 and 100 pulses: cmd_valid_o drops at once, no done_o; after release, ready = 1 and a SERVICE request yields a single 010 pulse.
- With TRAFFIC_SEQ_CHECK_EN, RECONFIG with yellow=0: err_o = 1 at k+1, no cmd_valid_o, ready high at k+1. Without the macro, the same request issues 101/0 at k+10.
- GAP_CYCLES = 0 parameterisation: RECONFIG gives back-to-back pulses k+1..k+5; done_o at k+6.
